lake_port_harness: RTL and testbench
====================================

// Module: lake_port_harness
// PURPOSE
//  Synthesizable stimulus/capture harness for lakespec-style memory tiles. It replaces hand-written
//  TB sequencing and is the next generation of that sequencing. It sequences the DUT flush, then
//  drives NUM_IN input ports with per-port ramp or constant patterns for cfg_num_cycles cycles.
//  Each cycle it captures NUM_OUT DUT output ports into an on-chip buffer that the host reads back.
//  It sits between the test controller and one lakespec instance, on the same clock.
// PARAMETERS
//  DATA_WIDTH    16    width of each DUT data port
//  NUM_IN        2     number of DUT input ports driven
//  NUM_OUT       2     number of DUT output ports captured
//  CAPTURE_DEPTH 1024  capture entries per output port (power of 2)
//  CYC_WIDTH     32    width of run-length config and run index
//  FLUSH_CYCLES  4     cycles dut_flush is held high before a run
// PORTS
//  clk            in  1                     clock
//  rst_n          in  1                     asynchronous active-low reset
//  start          in  1                     pulse: begin flush+run (accepted only in IDLE or DONE)
//  abort          in  1                     pulse: terminate flush/run, return to IDLE
//  cfg_num_cycles in  CYC_WIDTH             stimulus cycles per run
//  cfg_offset     in  NUM_IN*DATA_WIDTH     per-port start value (port k in slice k)
//  cfg_stride     in  NUM_IN*DATA_WIDTH     per-port increment per cycle
//  cfg_const      in  NUM_IN                per-port mode: 1=constant offset, 0=ramp
//  dut_flush      out 1                     flush to DUT
//  dut_in         out NUM_IN*DATA_WIDTH     stimulus to DUT input ports
//  dut_out        in  NUM_OUT*DATA_WIDTH    DUT output ports
//  rd_port        in  clog2(NUM_OUT)        capture readback port select
//  rd_addr        in  clog2(CAPTURE_DEPTH)  capture readback address
//  rd_data        out DATA_WIDTH            capture readback data, 1-cycle latency
//  busy           out 1                     high in FLUSH or RUN
//  done           out 1                     high in DONE
//  overflow       out 1                     sticky: run longer than CAPTURE_DEPTH
//  cycle_count    out 64                    free-running cycle counter since reset
// BEHAVIOUR
//  Reset: state=IDLE; dut_flush=0, dut_in=0, busy=0, done=0, overflow=0, cycle_count=0, rd_data=0.
//   Capture RAM contents are not reset.
//  FSM IDLE -> FLUSH on start. FLUSH lasts exactly FLUSH_CYCLES cycles with dut_flush=1, dut_in=0.
//  FLUSH -> RUN (idx=0). If cfg_num_cycles==0, FLUSH -> DONE instead.
//  RUN: dut_in slice k = cfg_const[k] ? offset[k] : offset[k] + idx*stride[k].
//   The product is computed by accumulation, mod 2^DATA_WIDTH; dut_in is registered.
//   Cycle idx presents stimulus idx. dut_out sampled at the end of that cycle is written to
//   capture[port][idx], but only when idx < CAPTURE_DEPTH.
//   idx >= CAPTURE_DEPTH: no write, no wrap; overflow set (sticky until next accepted start).
//   RUN -> DONE after the cycle with idx == cfg_num_cycles-1; dut_in returns to 0 in DONE.
//  DONE: done=1 until the next accepted start, which re-enters FLUSH and clears overflow.
//  start in FLUSH/RUN is ignored. abort in any state -> IDLE next cycle and drops dut_flush.
//   abort wins over a simultaneous start. Captured data is kept.
//  Config is sampled once at start acceptance; later changes do not affect the current run.
//  cycle_count increments every cycle after reset and wraps at 2^64.
//  Readback is legal in any state; a same-cycle write to the read address returns the old data.
//  rd_port >= NUM_OUT returns 0.
// TESTING
//  1 offset0=0, stride0=2, num_cycles=1000, loopback dut_out=dut_in -> capture[0][i]=2*i, done after 4+1000 cycles
//  2 cfg_const[1]=1, offset1=0x00AB -> dut_in port1 = 0x00AB every RUN cycle; dut_flush high exactly 4 cycles
//  3 num_cycles=1030, DEPTH=1024 -> entries 0..1023 written, overflow=1, next start clears it
//  4 offset=0xFFFE, stride=1 -> stimulus 0xFFFE, 0xFFFF, 0x0000 (wrap), no other effect
//  5 abort at idx=10 with start same cycle -> IDLE, busy=0, dut_flush=0; capture[0][0..9] intact
//  6 num_cycles=0 -> FLUSH 4 cycles then DONE; no capture writes; rst_n low mid-RUN -> all outputs 0

Source files
------------

// File: rtl/lake_port_if.sv
// lake_port_if: host-side control/config/readback bus plus the DUT stimulus/capture ports of the harness
interface lake_port_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_IN        = 2,
  parameter int NUM_OUT       = 2,
  parameter int CAPTURE_DEPTH = 1024,
  parameter int CYC_WIDTH     = 32
);
  localparam int AW = $clog2(CAPTURE_DEPTH);
  localparam int PW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  logic                          start;
  logic                          abort;
  logic [CYC_WIDTH-1:0]          cfg_num_cycles;
  logic [NUM_IN*DATA_WIDTH-1:0]  cfg_offset;
  logic [NUM_IN*DATA_WIDTH-1:0]  cfg_stride;
  logic [NUM_IN-1:0]             cfg_const;
  logic                          dut_flush;
  logic [NUM_IN*DATA_WIDTH-1:0]  dut_in;
  logic [NUM_OUT*DATA_WIDTH-1:0] dut_out;
  logic [PW-1:0]                 rd_port;
  logic [AW-1:0]                 rd_addr;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          busy;
  logic                          done;
  logic                          overflow;
  logic [63:0]                   cycle_count;
  modport master (
    output start, abort, cfg_num_cycles, cfg_offset, cfg_stride, cfg_const, dut_out, rd_port, rd_addr,
    input  dut_flush, dut_in, rd_data, busy, done, overflow, cycle_count
  );
  modport slave (
    input  start, abort, cfg_num_cycles, cfg_offset, cfg_stride, cfg_const, dut_out, rd_port, rd_addr,
    output dut_flush, dut_in, rd_data, busy, done, overflow, cycle_count
  );
endinterface

// File: rtl/lake_port_harness.sv
// lake_port_harness: flushes a lakespec tile, drives ramp/constant stimulus and captures its outputs
module lake_port_harness #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_IN        = 2,
  parameter int NUM_OUT       = 2,
  parameter int CAPTURE_DEPTH = 1024,
  parameter int CYC_WIDTH     = 32,
  parameter int FLUSH_CYCLES  = 4
) (
  input logic       clk,
  input logic       rst_n,
  lake_port_if.slave bus
);
  localparam int AW = $clog2(CAPTURE_DEPTH);
  localparam int PW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;
  state_t                       state;
  logic [FW-1:0]                fcnt;
  logic [CYC_WIDTH-1:0]         idx;
  logic [CYC_WIDTH-1:0]         num;
  logic [NUM_IN*DATA_WIDTH-1:0] off;
  logic [NUM_IN*DATA_WIDTH-1:0] stride;
  logic [NUM_IN-1:0]            cmode;
  logic [DATA_WIDTH-1:0]        mem [NUM_OUT][CAPTURE_DEPTH];
  logic                         in_range;
  logic                         wr;
  logic                         rd_ok;
  assign in_range = idx < CYC_WIDTH'(CAPTURE_DEPTH);
  assign wr = state == RUN && in_range && !bus.abort;
  if ((1 << PW) == NUM_OUT) begin : g_full
    assign rd_ok = 1'b1;
  end else begin : g_part
    assign rd_ok = int'(bus.rd_port) < NUM_OUT;
  end
  // Sequencer: flush, then step the per-port ramp one stimulus per cycle; abort always wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      fcnt          <= '0;
      idx           <= '0;
      num           <= '0;
      off           <= '0;
      stride        <= '0;
      cmode         <= '0;
      bus.dut_flush <= 1'b0;
      bus.dut_in    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.overflow  <= 1'b0;
    end else if (bus.abort) begin
      state         <= IDLE;
      bus.dut_flush <= 1'b0;
      bus.dut_in    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state         <= FLUSH;
          fcnt          <= '0;
          num           <= bus.cfg_num_cycles;
          off           <= bus.cfg_offset;
          stride        <= bus.cfg_stride;
          cmode         <= bus.cfg_const;
          bus.dut_flush <= 1'b1;
          bus.busy      <= 1'b1;
          bus.done      <= 1'b0;
          bus.overflow  <= 1'b0;
        end
        FLUSH: begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == FW'(FLUSH_CYCLES - 1)) begin
            state         <= num == '0 ? DONE : RUN;
            idx           <= '0;
            bus.dut_flush <= 1'b0;
            bus.busy      <= num != '0;
            bus.done      <= num == '0;
            bus.dut_in    <= num == '0 ? '0 : off;
          end
        end
        RUN: begin
          if (!in_range) bus.overflow <= 1'b1;
          if (idx == num - 1'b1) begin
            state      <= DONE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.dut_in <= '0;
          end else begin
            idx <= idx + 1'b1;
            for (int k = 0; k < NUM_IN; k++)
              bus.dut_in[k*DATA_WIDTH +: DATA_WIDTH] <= cmode[k] ? off[k*DATA_WIDTH +: DATA_WIDTH]
                : bus.dut_in[k*DATA_WIDTH +: DATA_WIDTH] + stride[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      endcase
    end
  // Capture RAM: one entry per output port per in-range run cycle, contents survive reset
  always_ff @(posedge clk)
    if (wr)
      for (int o = 0; o < NUM_OUT; o++)
        mem[o][idx[AW-1:0]] <= bus.dut_out[o*DATA_WIDTH +: DATA_WIDTH];
  // Readback register: reads before a same-cycle write, so the old entry is returned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.rd_data <= '0;
    else bus.rd_data <= rd_ok ? mem[bus.rd_port][bus.rd_addr] : '0;
  // Free-running cycle counter since reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.cycle_count <= '0;
    else bus.cycle_count <= bus.cycle_count + 64'd1;
endmodule

// File: tb/tb_lake_port_harness.sv
// tb_lake_port_harness: table-driven runs with loopback capture plus hand-written flush/abort/reset sequences
module tb_lake_port_harness;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  lake_port_if #(.DATA_WIDTH(16), .NUM_IN(2), .NUM_OUT(2), .CAPTURE_DEPTH(1024), .CYC_WIDTH(32)) bus ();
  lake_port_harness #(
    .DATA_WIDTH(16), .NUM_IN(2), .NUM_OUT(2), .CAPTURE_DEPTH(1024), .CYC_WIDTH(32), .FLUSH_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.dut_out = bus.dut_in;

  typedef struct {
    logic [15:0] off0, st0;
    logic        c0;
    logic [15:0] off1, st1;
    logic        c1;
    int          num;
    int          addr;
    logic [15:0] e0, e1;
    logic        ovf;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] o0, s0, input logic k0, input logic [15:0] o1, s1,
                         input logic k1, input int n);
    bus.cfg_offset     = {o1, o0};
    bus.cfg_stride     = {s1, s0};
    bus.cfg_const      = {k1, k0};
    bus.cfg_num_cycles = n;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 3000) begin
      step();
      lat++;
    end
  endtask

  task automatic readback(input int p, input int a, output logic [15:0] d);
    bus.rd_port = 1'(p);
    bus.rd_addr = 10'(a);
    step();
    d = bus.rd_data;
  endtask

  initial begin
    int          lat, nf, bad;
    logic [15:0] d;
    logic [63:0] c0;
    bus.start = 0; bus.abort = 0; bus.rd_port = 0; bus.rd_addr = 0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{16'h0000, 16'h0002, 1'b0, 16'h00AB, 16'h0005, 1'b1, 1000,    0, 16'h0000, 16'h00AB, 1'b0};
    tbl[1] = '{16'h0000, 16'h0002, 1'b0, 16'h00AB, 16'h0005, 1'b1, 1000,  999, 16'h07CE, 16'h00AB, 1'b0};
    tbl[2] = '{16'h0000, 16'h0002, 1'b0, 16'h00AB, 16'h0005, 1'b1, 1000,  500, 16'h03E8, 16'h00AB, 1'b0};
    tbl[3] = '{16'hFFFE, 16'h0001, 1'b0, 16'h0010, 16'h0003, 1'b0,    3,    2, 16'h0000, 16'h0016, 1'b0};
    tbl[4] = '{16'hFFFE, 16'h0001, 1'b0, 16'h0010, 16'h0003, 1'b0,    3,    1, 16'hFFFF, 16'h0013, 1'b0};
    tbl[5] = '{16'hFFFE, 16'h0001, 1'b0, 16'h0010, 16'h0003, 1'b0,    3,    0, 16'hFFFE, 16'h0010, 1'b0};
    tbl[6] = '{16'h0007, 16'hFFFF, 1'b0, 16'h8000, 16'h8000, 1'b0,   20,    9, 16'hFFFE, 16'h0000, 1'b0};
    tbl[7] = '{16'h0007, 16'hFFFF, 1'b0, 16'h8000, 16'h8000, 1'b0,   20,    8, 16'hFFFF, 16'h8000, 1'b0};
    tbl[8] = '{16'h0100, 16'h0010, 1'b1, 16'h0000, 16'h0001, 1'b0, 1030, 1023, 16'h0100, 16'h03FF, 1'b1};
    tbl[9] = '{16'h0100, 16'h0010, 1'b1, 16'h0000, 16'h0001, 1'b0, 1030,    0, 16'h0100, 16'h0000, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    check("reset_flush", bus.dut_flush, 0);
    check("reset_dut_in", bus.dut_in, 0);
    check("reset_busy_done_ovf", {bus.busy, bus.done, bus.overflow}, 0);
    check("reset_cycle_count", bus.cycle_count, 0);
    check("reset_rd_data", bus.rd_data, 0);
    rst_n = 1'b1;
    step();
    c0 = bus.cycle_count;
    repeat (7) step();
    check("cycle_count_delta", bus.cycle_count - c0, 7);
    for (int i = 0; i < 10; i++) begin
      set_cfg(tbl[i].off0, tbl[i].st0, tbl[i].c0, tbl[i].off1, tbl[i].st1, tbl[i].c1, tbl[i].num);
      pulse_start();
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, 4 + tbl[i].num);
      check($sformatf("v%0d_overflow", i), bus.overflow, tbl[i].ovf);
      readback(0, tbl[i].addr, d);
      check($sformatf("v%0d_cap0[%0d]", i, tbl[i].addr), d, tbl[i].e0);
      readback(1, tbl[i].addr, d);
      check($sformatf("v%0d_cap1[%0d]", i, tbl[i].addr), d, tbl[i].e1);
    end
    set_cfg(0, 1, 0, 0, 1, 0, 5);
    pulse_start();
    check("restart_clears_overflow", bus.overflow, 0);
    check("flush_busy", {bus.busy, bus.done}, 2'b10);
    nf = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.dut_flush) begin
        nf++;
        if (bus.dut_in != 0) bad++;
      end
      step();
    end
    check("flush_cycles", nf, 4);
    check("flush_dut_in_zero", bad, 0);
    check("short_run_done", bus.done, 1);
    check("done_dut_in_zero", bus.dut_in, 0);
    set_cfg(16'h0040, 16'h0001, 0, 16'h00AB, 16'h0007, 1, 100);
    pulse_start();
    set_cfg(16'h5555, 16'h0003, 0, 16'h1111, 16'h0001, 0, 2);
    repeat (4) step();
    check("run_idx0", bus.dut_in, {16'h00AB, 16'h0040});
    repeat (5) step();
    pulse_start();
    repeat (4) step();
    check("run_idx10_stimulus", bus.dut_in, {16'h00AB, 16'h004A});
    check("run_idx10_busy", bus.busy, 1);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_state", {bus.busy, bus.done, bus.dut_flush}, 0);
    check("abort_dut_in", bus.dut_in, 0);
    step();
    check("abort_stays_idle", {bus.busy, bus.dut_flush}, 0);
    readback(0, 9, d);
    check("abort_cap0[9]", d, 16'h0049);
    readback(0, 0, d);
    check("abort_cap0[0]", d, 16'h0040);
    readback(1, 5, d);
    check("abort_cap1[5]", d, 16'h00AB);
    set_cfg(16'h1234, 16'h0001, 0, 16'h4321, 16'h0001, 0, 0);
    pulse_start();
    wait_done(lat);
    check("zero_run_latency", lat, 4);
    check("zero_run_busy", bus.busy, 0);
    readback(0, 0, d);
    check("zero_run_no_write", d, 16'h0040);
    set_cfg(16'h0300, 16'h0002, 0, 16'h0000, 16'h0001, 0, 50);
    pulse_start();
    repeat (10) step();
    check("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_flush_dut_in", {bus.dut_flush, bus.dut_in}, 0);
    check("midrun_reset_status", {bus.busy, bus.done, bus.overflow}, 0);
    check("midrun_reset_counters", {bus.cycle_count, bus.rd_data}, 0);
    step();
    rst_n = 1'b1;
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
